// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: storage array, wrap-bit pointers, registered status flags,
// sticky error flags and first-word-fall-through read data.
module sync_fifo_ctrl #(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned ADDR_SIZE  = 4,
  parameter int unsigned AFULL_LVL  = 12,
  parameter int unsigned AEMPTY_LVL = 2
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic                 rempty,
  output logic                 ralmost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;
  localparam int unsigned PW    = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LVL);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LVL);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          wfull_q, wfull_d;
  logic          rempty_q, rempty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_ok, rd_ok;

  // Acceptance uses the registered flags; next flags come from next pointers/count.
  always_comb begin
    wr_ok    = winc & ~wfull_q;
    rd_ok    = rinc & ~rempty_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    if (wr_ok) wptr_d = wptr_q + PW'(1);
    if (rd_ok) rptr_d = rptr_q + PW'(1);
    count_d  = count_q + PW'(wr_ok) - PW'(rd_ok);
    wfull_d  = (wptr_d[ADDR_SIZE] != rptr_d[ADDR_SIZE]) &&
               (wptr_d[ADDR_SIZE-1:0] == rptr_d[ADDR_SIZE-1:0]);
    rempty_d = (wptr_d == rptr_d);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
    ovf_d    = ovf_q | (winc & wfull_q);
    unf_d    = unf_q | (rinc & rempty_q);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge wclk) begin
    if (wr_ok && !wrst) mem_q[wptr_q[ADDR_SIZE-1:0]] <= wdata;
  end

  assign rdata         = mem_q[rptr_q[ADDR_SIZE-1:0]];
  assign wfull         = wfull_q;
  assign walmost_full  = afull_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = aempty_q;
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule
